// File: rtl/dijkstra_top.sv
// Single-source shortest-path engine: reads an NxN weight matrix over a shared
// memory bus, runs Dijkstra, and writes the predecessor array after the matrix.
module dijkstra_top #(
    parameter int MADDR_WIDTH = 32,
    parameter int MDATA_WIDTH = 32,
    parameter int MAX_NODES   = 16,
    parameter int INDEX_WIDTH = 8,
    parameter int VALUE_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [INDEX_WIDTH-1:0] source,
    input  logic [INDEX_WIDTH-1:0] destination,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    input  logic [MADDR_WIDTH-1:0] base_address,
    inout  wire                    mem_read_enable,
    inout  wire                    mem_write_enable,
    input  logic                   mem_write_ready,
    input  logic                   mem_read_ready,
    inout  wire  [MADDR_WIDTH-1:0] mem_addr,
    input  logic [MDATA_WIDTH-1:0] mem_read_data,
    inout  wire  [MDATA_WIDTH-1:0] mem_write_data,
    output logic                   ready
);
    localparam int NW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
    localparam logic [INDEX_WIDTH-1:0] NO_PREV = '1;
    localparam logic [VALUE_WIDTH-1:0] INF     = '1;
    localparam logic [INDEX_WIDTH-1:0] MAX_N   = INDEX_WIDTH'(MAX_NODES);
    localparam logic [INDEX_WIDTH-1:0] ONE     = INDEX_WIDTH'(1);
    localparam logic [MADDR_WIDTH-1:0] STEP    = MADDR_WIDTH'(MADDR_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_SELECT, S_READ_EDGE, S_RELAX, S_WRITE_PREV, S_WRITE_GAP, S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [INDEX_WIDTH-1:0] r_src, r_dest, r_n, r_idx, r_u, r_v;
    logic [MADDR_WIDTH-1:0] r_base;
    logic [VALUE_WIDTH-1:0] r_weight;
    logic [VALUE_WIDTH-1:0] r_dist [MAX_NODES];
    logic [INDEX_WIDTH-1:0] r_prev [MAX_NODES];
    logic [MAX_NODES-1:0]   r_visited;

    logic [INDEX_WIDTH-1:0] w_n_clamp, w_sel;
    logic                   w_found;
    logic [VALUE_WIDTH-1:0] w_best, w_sum;
    logic [NW-1:0]          w_idx_i, w_u_i, w_v_i, w_src_i;
    logic                   w_bus_en, w_rd_en, w_wr_en;
    logic [MADDR_WIDTH-1:0] w_addr, w_rd_addr, w_wr_addr;
    logic [MDATA_WIDTH-1:0] w_wdata;
    logic                   w_unused;

    function automatic logic [VALUE_WIDTH-1:0] sat_add(input logic [VALUE_WIDTH-1:0] a,
                                                       input logic [VALUE_WIDTH-1:0] b);
        logic [VALUE_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[VALUE_WIDTH] ? INF : s[VALUE_WIDTH-1:0];
    endfunction

    assign w_n_clamp = (number_of_nodes > MAX_N) ? MAX_N : number_of_nodes;
    assign w_idx_i   = r_idx[NW-1:0];
    assign w_u_i     = r_u[NW-1:0];
    assign w_v_i     = r_v[NW-1:0];
    assign w_src_i   = r_src[NW-1:0];
    assign w_sum     = sat_add(r_dist[w_u_i], r_weight);
    assign w_rd_addr = r_base + (MADDR_WIDTH'(r_u) * MADDR_WIDTH'(r_n) + MADDR_WIDTH'(r_v)) * STEP;
    assign w_wr_addr = r_base + (MADDR_WIDTH'(r_n) * MADDR_WIDTH'(r_n) + MADDR_WIDTH'(r_idx)) * STEP;
    assign w_unused  = ^{r_dest, mem_read_data[MDATA_WIDTH-1:VALUE_WIDTH]};

    // Strict less-than while scanning upward keeps the lowest index on ties and rejects INF
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_best  = INF;
        for (int i = 0; i < MAX_NODES; i++) begin
            if (INDEX_WIDTH'(i) < r_n && !r_visited[i] && r_dist[i] < w_best) begin
                w_found = 1'b1;
                w_sel   = INDEX_WIDTH'(i);
                w_best  = r_dist[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (enable) w_next = (w_n_clamp == '0) ? S_DONE : S_INIT;
            S_INIT:       if (r_idx == r_n - ONE) w_next = (r_src < r_n) ? S_SELECT : S_WRITE_PREV;
            S_SELECT:     w_next = w_found ? S_READ_EDGE : S_WRITE_PREV;
            S_READ_EDGE:  if (mem_read_ready) w_next = S_RELAX;
            S_RELAX:      w_next = (r_v + ONE < r_n) ? S_READ_EDGE : S_SELECT;
            S_WRITE_PREV: if (mem_write_ready) w_next = S_WRITE_GAP;
            S_WRITE_GAP:  w_next = (r_idx == r_n) ? S_DONE : S_WRITE_PREV;
            S_DONE:       w_next = S_DONE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_bus_en = (r_state != S_IDLE) && (r_state != S_DONE);
        w_rd_en  = (r_state == S_READ_EDGE);
        w_wr_en  = (r_state == S_WRITE_PREV);
        w_addr   = (r_state == S_WRITE_PREV) ? w_wr_addr : w_rd_addr;
        w_wdata  = MDATA_WIDTH'(r_prev[w_idx_i]);
        ready    = (r_state == S_DONE);
    end

    assign mem_read_enable  = w_bus_en ? w_rd_en : 1'bz;
    assign mem_write_enable = w_bus_en ? w_wr_en : 1'bz;
    assign mem_addr         = w_bus_en ? w_addr  : {MADDR_WIDTH{1'bz}};
    assign mem_write_data   = w_bus_en ? w_wdata : {MDATA_WIDTH{1'bz}};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_visited <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_src  <= source;
                        r_dest <= destination;
                        r_base <= base_address;
                        r_n    <= w_n_clamp;
                        r_idx  <= '0;
                    end
                end
                S_INIT: begin
                    r_dist[w_idx_i]    <= INF;
                    r_prev[w_idx_i]    <= NO_PREV;
                    r_visited[w_idx_i] <= 1'b0;
                    r_idx              <= r_idx + ONE;
                    if (r_idx == r_n - ONE) begin
                        r_idx <= '0;
                        if (r_src < r_n) r_dist[w_src_i] <= '0;
                    end
                end
                S_SELECT: begin
                    r_idx <= '0;
                    if (w_found) begin
                        r_visited[w_sel[NW-1:0]] <= 1'b1;
                        r_u <= w_sel;
                        r_v <= '0;
                    end
                end
                S_READ_EDGE: begin
                    if (mem_read_ready) r_weight <= mem_read_data[VALUE_WIDTH-1:0];
                end
                S_RELAX: begin
                    if (!r_visited[w_v_i] && r_weight != '0 && w_sum < r_dist[w_v_i]) begin
                        r_dist[w_v_i] <= w_sum;
                        r_prev[w_v_i] <= r_u;
                    end
                    r_v <= r_v + ONE;
                end
                S_WRITE_PREV: begin
                    if (mem_write_ready) r_idx <= r_idx + ONE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dijkstra_top.sv
// Directed bench for dijkstra_top: a host loads graphs over the shared bus, starts
// the engine, and reads back the predecessor array against hand-computed values.
module tb_dijkstra_top;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable;
    logic [7:0]  source, destination, number_of_nodes;
    logic [31:0] base_address;
    wire         mem_read_enable, mem_write_enable;
    wire  [31:0] mem_addr, mem_write_data;
    logic        mem_read_ready = 1'b0;
    logic        mem_write_ready = 1'b0;
    logic [31:0] mem_read_data = 32'h0;
    logic        ready;

    logic        host_drv, host_rd, host_wr;
    logic [31:0] host_addr, host_wdata;

    logic [31:0] mem [0:1023];
    int lat;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int overlap_cnt = 0;
    int post_ready_cnt = 0;
    int errors = 0;
    int checks = 0;
    int tmo_cnt = 0;
    int wmat [64];
    logic [31:0] got [16];

    assign mem_read_enable  = host_drv ? host_rd    : 1'bz;
    assign mem_write_enable = host_drv ? host_wr    : 1'bz;
    assign mem_addr         = host_drv ? host_addr  : 32'bz;
    assign mem_write_data   = host_drv ? host_wdata : 32'bz;

    dijkstra_top dut (
        .clock(clk), .reset(reset), .enable(enable), .source(source),
        .destination(destination), .number_of_nodes(number_of_nodes),
        .base_address(base_address), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .mem_write_ready(mem_write_ready),
        .mem_read_ready(mem_read_ready), .mem_addr(mem_addr),
        .mem_read_data(mem_read_data), .mem_write_data(mem_write_data), .ready(ready)
    );

    // Memory with a programmable number of wait states, plus bus monitors
    always @(posedge clk) begin
        mem_read_ready  <= 1'b0;
        mem_write_ready <= 1'b0;
        if (mem_read_enable === 1'b1 && mem_read_ready !== 1'b1) begin
            if (rd_cnt >= lat) begin
                mem_read_ready <= 1'b1;
                mem_read_data  <= mem[mem_addr[11:2]];
                rd_cnt         <= 0;
            end else rd_cnt <= rd_cnt + 1;
        end else rd_cnt <= 0;
        if (mem_write_enable === 1'b1 && mem_write_ready !== 1'b1) begin
            if (wr_cnt >= lat) begin
                mem_write_ready         <= 1'b1;
                mem[mem_addr[11:2]]     <= mem_write_data;
                wr_cnt                  <= 0;
            end else wr_cnt <= wr_cnt + 1;
        end else wr_cnt <= 0;
        if (mem_read_enable === 1'b1 && mem_write_enable === 1'b1) overlap_cnt <= overlap_cnt + 1;
        if (ready === 1'b1 && !host_drv && (mem_read_enable === 1'b1 || mem_write_enable === 1'b1))
            post_ready_cnt <= post_ready_cnt + 1;
    end

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1; enable = 1'b0;
        @(negedge clk); @(negedge clk); reset = 1'b0;
    endtask

    task automatic host_write(input logic [31:0] a, input logic [31:0] d);
        int k;
        @(negedge clk); host_drv = 1'b1; host_addr = a; host_wdata = d; host_rd = 1'b0; host_wr = 1'b1;
        k = 0;
        while (mem_write_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) tmo_cnt++;
        host_wr = 1'b0;
        @(negedge clk); host_drv = 1'b0;
    endtask

    task automatic host_read(input logic [31:0] a, output logic [31:0] d);
        int k;
        @(negedge clk); host_drv = 1'b1; host_addr = a; host_rd = 1'b1; host_wr = 1'b0;
        k = 0;
        while (mem_read_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) tmo_cnt++;
        d = mem_read_data;
        host_rd = 1'b0;
        @(negedge clk); host_drv = 1'b0;
    endtask

    task automatic clear_wmat();
        for (int i = 0; i < 64; i++) wmat[i] = 0;
    endtask

    // Matrix from wmat[r*n+c]; prev slots are pre-filled with 0x55 so stale data cannot pass
    task automatic load_graph(input logic [31:0] base, input int n);
        for (int i = 0; i < n * n; i++) host_write(base + 32'(i * 4), 32'(wmat[i]));
        for (int j = 0; j < n; j++) host_write(base + 32'((n * n + j) * 4), 32'h55);
    endtask

    task automatic read_prev(input logic [31:0] base, input int n);
        logic [31:0] d;
        for (int j = 0; j < n; j++) begin
            host_read(base + 32'((n * n + j) * 4), d);
            got[j] = d;
        end
    endtask

    task automatic run_dut(input logic [7:0] src, input logic [7:0] n, input logic [31:0] base,
                           output bit to);
        @(negedge clk);
        source = src; number_of_nodes = n; base_address = base; destination = 8'd0; enable = 1'b1;
        @(negedge clk); enable = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 20000; k++) begin
            if (ready === 1'b1) begin to = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        pulse_reset();
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        repeat (5) @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b expected 0", ready); end
        checks++;
        if (mem_read_enable === 1'b1 || mem_write_enable === 1'b1) begin
            errors++; $display("FAIL idle_enables: got rd=%b wr=%b expected released", mem_read_enable, mem_write_enable);
        end
    endtask

    task automatic test_chain();
        bit to;
        logic [31:0] exp [8] = '{32'hFF, 32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
        pulse_reset(); lat = 0;
        clear_wmat();
        for (int i = 0; i < 7; i++) wmat[i * 8 + i + 1] = 1;
        load_graph(32'h100, 8);
        run_dut(8'd0, 8'd8, 32'h100, to);
        checks++; if (to || ready !== 1'b1) begin errors++; $display("FAIL chain_ready: got %b expected 1", ready); end
        read_prev(32'h100, 8);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (got[j] !== exp[j]) begin errors++; $display("FAIL chain_prev[%0d]: got %h expected %h", j, got[j], exp[j]); end
        end
    endtask

    task automatic test_shortcut();
        bit to;
        logic [31:0] exp [4] = '{32'hFF, 32'h2, 32'h0, 32'h1};
        pulse_reset(); lat = 2;
        clear_wmat();
        wmat[0 * 4 + 1] = 5; wmat[0 * 4 + 2] = 1; wmat[2 * 4 + 1] = 1; wmat[1 * 4 + 3] = 1;
        load_graph(32'h400, 4);
        run_dut(8'd0, 8'd4, 32'h400, to);
        checks++; if (to || ready !== 1'b1) begin errors++; $display("FAIL shortcut_ready: got %b expected 1", ready); end
        read_prev(32'h400, 4);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (got[j] !== exp[j]) begin errors++; $display("FAIL shortcut_prev[%0d]: got %h expected %h", j, got[j], exp[j]); end
        end
    endtask

    task automatic test_tie();
        bit to;
        logic [31:0] exp [3] = '{32'hFF, 32'h0, 32'h0};
        pulse_reset(); lat = 1;
        clear_wmat();
        wmat[0 * 3 + 1] = 2; wmat[0 * 3 + 2] = 1; wmat[2 * 3 + 1] = 1;
        load_graph(32'h600, 3);
        run_dut(8'd0, 8'd3, 32'h600, to);
        checks++; if (to || ready !== 1'b1) begin errors++; $display("FAIL tie_ready: got %b expected 1", ready); end
        read_prev(32'h600, 3);
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (got[j] !== exp[j]) begin errors++; $display("FAIL tie_prev[%0d]: got %h expected %h", j, got[j], exp[j]); end
        end
    endtask

    task automatic test_unreachable();
        bit to;
        logic [31:0] exp [4] = '{32'hFF, 32'h0, 32'hFF, 32'hFF};
        pulse_reset(); lat = 0;
        clear_wmat();
        wmat[0 * 4 + 1] = 3;
        load_graph(32'h800, 4);
        run_dut(8'd0, 8'd4, 32'h800, to);
        checks++; if (to || ready !== 1'b1) begin errors++; $display("FAIL unreach_ready: got %b expected 1", ready); end
        read_prev(32'h800, 4);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (got[j] !== exp[j]) begin errors++; $display("FAIL unreach_prev[%0d]: got %h expected %h", j, got[j], exp[j]); end
        end
    endtask

    task automatic test_boundary();
        bit to;
        logic [31:0] d;
        pulse_reset(); lat = 1;
        host_write(32'hE00, 32'h55);
        run_dut(8'd0, 8'd0, 32'hE00, to);
        checks++; if (to || ready !== 1'b1) begin errors++; $display("FAIL n0_ready: got %b expected 1", ready); end
        host_read(32'hE00, d);
        checks++; if (d !== 32'h55) begin errors++; $display("FAIL n0_no_write: got %h expected 00000055", d); end
        pulse_reset();
        clear_wmat();
        wmat[0 * 3 + 1] = 1; wmat[1 * 3 + 2] = 1;
        load_graph(32'hE40, 3);
        run_dut(8'd5, 8'd3, 32'hE40, to);
        checks++; if (to || ready !== 1'b1) begin errors++; $display("FAIL badsrc_ready: got %b expected 1", ready); end
        read_prev(32'hE40, 3);
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (got[j] !== 32'hFF) begin errors++; $display("FAIL badsrc_prev[%0d]: got %h expected 000000ff", j, got[j]); end
        end
    endtask

    task automatic test_bus_release();
        bit to;
        logic [31:0] d;
        logic [31:0] exp [5] = '{32'hFF, 32'hFF, 32'h3, 32'h4, 32'h0};
        pulse_reset(); lat = 0;
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            host_drv = 1'b1; host_rd = 1'b0; host_wr = 1'b0;
            host_addr = (p == 0) ? 32'h0 : 32'hFFFF_FFFF; host_wdata = host_addr ^ 32'h5A5A_5A5A;
            #1;
            checks++; if (mem_addr !== host_addr) begin errors++; $display("FAIL idle_addr: got %h expected %h", mem_addr, host_addr); end
            checks++; if (mem_write_data !== host_wdata) begin errors++; $display("FAIL idle_wdata: got %h expected %h", mem_write_data, host_wdata); end
        end
        @(negedge clk); host_drv = 1'b0;
        clear_wmat();
        wmat[0 * 3 + 1] = 4;
        load_graph(32'hA00, 3);
        run_dut(8'd0, 8'd3, 32'hA00, to);
        checks++; if (to || ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", ready); end
        @(negedge clk);
        host_drv = 1'b1; host_rd = 1'b0; host_wr = 1'b0; host_addr = 32'h0; host_wdata = 32'h0;
        #1;
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL done_addr: got %h expected 00000000", mem_addr); end
        @(negedge clk); host_drv = 1'b0;
        host_write(32'hFF0, 32'h1234_ABCD);
        host_read(32'hFF0, d);
        checks++; if (d !== 32'h1234_ABCD) begin errors++; $display("FAIL done_host_rw: got %h expected 1234abcd", d); end
        pulse_reset();
        clear_wmat();
        wmat[0 * 5 + 4] = 2; wmat[4 * 5 + 3] = 2; wmat[3 * 5 + 2] = 2; wmat[0 * 5 + 2] = 9;
        load_graph(32'hB00, 5);
        run_dut(8'd0, 8'd5, 32'hB00, to);
        checks++; if (to || ready !== 1'b1) begin errors++; $display("FAIL rerun_ready: got %b expected 1", ready); end
        read_prev(32'hB00, 5);
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (got[j] !== exp[j]) begin errors++; $display("FAIL rerun_prev[%0d]: got %h expected %h", j, got[j], exp[j]); end
        end
    endtask

    task automatic test_mid_reset();
        bit to;
        int act;
        logic [31:0] exp [4] = '{32'hFF, 32'h2, 32'h0, 32'h1};
        pulse_reset(); lat = 1;
        clear_wmat();
        wmat[0 * 4 + 1] = 5; wmat[0 * 4 + 2] = 1; wmat[2 * 4 + 1] = 1; wmat[1 * 4 + 3] = 1;
        load_graph(32'hC00, 4);
        @(negedge clk);
        source = 8'd0; number_of_nodes = 8'd4; base_address = 32'hC00; enable = 1'b1;
        @(negedge clk); enable = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midrun_busy: got %b expected 0", ready); end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", ready); end
        act = 0;
        for (int k = 0; k < 6; k++) begin
            if (mem_read_enable === 1'b1 || mem_write_enable === 1'b1) act++;
            @(negedge clk); #1;
        end
        checks++; if (act !== 0) begin errors++; $display("FAIL abort_bus: got %0d active cycles expected 0", act); end
        run_dut(8'd0, 8'd4, 32'hC00, to);
        checks++; if (to || ready !== 1'b1) begin errors++; $display("FAIL restart_ready: got %b expected 1", ready); end
        read_prev(32'hC00, 4);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (got[j] !== exp[j]) begin errors++; $display("FAIL restart_prev[%0d]: got %h expected %h", j, got[j], exp[j]); end
        end
        checks++;
        if (overlap_cnt !== 0 || post_ready_cnt !== 0 || tmo_cnt !== 0) begin
            errors++;
            $display("FAIL bus_protocol: got overlap=%0d post_ready=%0d timeouts=%0d expected all 0",
                     overlap_cnt, post_ready_cnt, tmo_cnt);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; source = 8'd0; destination = 8'd0;
        number_of_nodes = 8'd0; base_address = 32'h0;
        host_drv = 1'b0; host_rd = 1'b0; host_wr = 1'b0; host_addr = 32'h0; host_wdata = 32'h0;
        lat = 0;
        test_reset();
        test_chain();
        test_shortcut();
        test_tie();
        test_unreachable();
        test_boundary();
        test_bus_release();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dijkstra_top.md
Name: dijkstra_top

Overview:
- Hardware single-source shortest-path engine using Dijkstra's algorithm.
- Reads an N×N adjacency matrix of edge weights from a shared word-addressed memory bus (BlockRam).
- Computes the shortest-path tree from a source node.
- Writes the predecessor ("prev") array back to memory directly after the matrix, then raises ready.
- Shares the memory bus with a host: it drives the bus only while running and tri-states it otherwise.

Parameters:
MADDR_WIDTH, 32, memory address width; address stride per word is MADDR_WIDTH/8 (4).
MDATA_WIDTH, 32, memory data width.
MAX_NODES, 16, maximum graph size (internal dist/prev/visited storage depth).
INDEX_WIDTH, 8, node index width.
VALUE_WIDTH, 16, edge weight / distance width.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  start request, sampled in IDLE.
source  in  INDEX_WIDTH  source node.
destination  in  INDEX_WIDTH  destination node; latched only, does not shorten the run.
number_of_nodes  in  INDEX_WIDTH  N.
base_address  in  MADDR_WIDTH  byte address of matrix element [0][0].
mem_read_enable  inout  1  read request; driven only while running, else z.
mem_write_enable  inout  1  write request; driven only while running, else z.
mem_write_ready  in  1  memory write complete.
mem_read_ready  in  1  memory read data valid.
mem_addr  inout  MADDR_WIDTH  bus address; driven only while running, else z.
mem_read_data  in  MDATA_WIDTH  read data.
mem_write_data  inout  MDATA_WIDTH  write data; driven only while running, else z.
ready  out  1  result written; held until reset.

Behaviour:
Memory layout:
- Define step = MADDR_WIDTH/8.
- Edge weight [r][c] is at base_address + (r*N+c)*step.
- prev[j] is written to base_address + (N*N+j)*step, zero-extended to MDATA_WIDTH.
- Edge weight = mem_read_data[VALUE_WIDTH-1:0]. Weight 0 means no edge.

Memory handshake:
- Read: drive addr and read_enable=1; hold until mem_read_ready=1; capture data on that edge; drop read_enable for at least one cycle.
- Write: drive addr, data and write_enable=1; hold until mem_write_ready=1; drop write_enable for at least one cycle.
- Never assert read and write enables together.

Constants:
- NO_PREVIOUS_NODE = all ones of INDEX_WIDTH (0xFF).
- INF = all ones of VALUE_WIDTH.

Reset:
- Enter IDLE; ready=0; all bus outputs z; visited cleared.
- Reset mid-run aborts immediately; no further bus activity.

States:
- IDLE: bus z. If enable=1, latch source, destination, base_address and N, then go to INIT.
  - N is clamped to MAX_NODES.
  - N=0 goes directly to DONE.
- INIT, one node per cycle: dist[i]=INF, prev[i]=NO_PREVIOUS_NODE, visited[i]=0. Then set dist[source]=0.
  - If source ≥ N, skip to WRITE_PREV with all prev = NO_PREVIOUS_NODE.
- SELECT: scan i=0..N-1 for an unvisited node with minimum dist < INF.
  - Ties go to the lowest index.
  - If none is found, or every node is visited, go to WRITE_PREV.
  - Otherwise u = selected node, visited[u]=1, v=0, go to READ_EDGE.
- READ_EDGE: read weight [u][v], then go to RELAX.
- RELAX: if v unvisited, w≠0, and sat(dist[u]+w) < dist[v] (strictly less), then dist[v]=sum and prev[v]=u.
  - sat() saturates at INF.
  - v++. If v<N go to READ_EDGE, else go to SELECT.
- WRITE_PREV: write prev[0..N-1] in ascending order, then go to DONE.
- DONE: ready=1; bus z; remain in DONE, ignoring enable, until reset.

Other rules:
- Source and unreachable nodes keep prev = NO_PREVIOUS_NODE.
- The graph is directed; the matrix is not required to be symmetric.
- Latency is not fixed; it depends on memory wait states. No memory access occurs after ready rises.

Test Plan:
1. N=8, source=0, chain 0→1→…→7 with weight 1 each, others 0 → ready=1; prev at base+(64+j)*4 = FF,0,1,2,3,4,5,6.
2. N=4, edges 0→1=5, 0→2=1, 2→1=1, 1→3=1 → prev = FF,2,0,1 (path through 2 wins, strict compare).
3. Tie: N=3, edges 0→1=2, 0→2=1, 2→1=1 → prev[1]=0 (equal cost, no update); prev = FF,0,0.
4. Unreachable: N=4, only edge 0→1=3 → prev = FF,0,FF,FF; ready asserted.
5. Bus release: host writes or reads memory while the block is in IDLE/DONE → host traffic is unaffected, block outputs z; a second run after reset with new N works correctly.
6. Reset pulsed mid-run → ready=0, bus z the next cycle; the run restarts when enable=1 and completes with correct prev.
